led_status_drv: RTL and testbench

LED_STATUS_DRV -- requirements
Module: led_status_drv

---
 rtl/led_status_drv_pkg.sv | 10 +
 rtl/led_status_drv_blink_gen.sv | 28 ++
 rtl/led_status_drv.sv | 53 +++++
 tb/tb_led_status_drv.sv | 115 +++++++++++
 4 files changed

// File: rtl/led_status_drv_pkg.sv
// led_status_drv_pkg: display mode encodings and default blink divider
package led_status_drv_pkg;
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ALARM  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;
  localparam int unsigned DIV_DEFAULT = 25_000_000;
endpackage

// File: rtl/led_status_drv_blink_gen.sv
// blink_gen: half-period prescaler producing the blink phase, restartable lit
module blink_gen
  import led_status_drv_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt, cnt_e;
  logic ph;
  // a restart makes the current cycle count as cnt=0 with phase lit, overriding a wrap
  assign cnt_e = restart ? '0 : cnt;
  assign phase = restart | ph;
  // count 0..DIV-1 and toggle phase on wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ph  <= 1'b1;
    end else begin
      cnt <= cnt_e == LAST ? '0 : cnt_e + 1'b1;
      ph  <= cnt_e == LAST ? ~phase : phase;
    end
endmodule

// File: rtl/led_status_drv.sv
// led_status_drv: snapshot, bit-reverse and blink multi-channel status LEDs with threshold alarm
module led_status_drv
  import led_status_drv_pkg::*;
#(
  parameter int          CH  = 2,
  parameter int          W   = 4,
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH*W-1:0] values,
  input  logic [1:0]      mode,
  input  logic [W-1:0]    thresh,
  input  logic            hold,
  output logic [CH*W-1:0] light,
  output logic            alarm
);
  logic [CH*W-1:0] snap, d, nxt;
  logic [CH-1:0]   over;
  logic [1:0]      prev_mode;
  logic            restart, phase;
  assign restart = mode != prev_mode && (mode == MODE_BLINK || mode == MODE_ALARM);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar i = 0; i < W; i++) begin : g_bit
      assign d[c*W+i] = snap[c*W+W-1-i];
    end
    assign over[c] = snap[c*W +: W] > thresh;
    assign nxt[c*W +: W] = mode == MODE_OFF ||
                           (!phase && (mode == MODE_BLINK || (mode == MODE_ALARM && over[c])))
                           ? '0 : d[c*W +: W];
  end
  blink_gen #(.DIV(DIV)) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .phase  (phase)
  );
  // snapshot follows values unless held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) snap <= '0;
    else if (!hold) snap <= values;
  // registered LED drive, alarm and mode history for entry detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      light     <= '0;
      alarm     <= 1'b0;
      prev_mode <= MODE_DIRECT;
    end else begin
      light     <= nxt;
      alarm     <= |over;
      prev_mode <= mode;
    end
endmodule

// File: tb/tb_led_status_drv.sv
// tb_led_status_drv: directed self-checking bench for led_status_drv (CH=2, W=4, DIV=4)
module tb_led_status_drv;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] values;
  logic [1:0] mode;
  logic [3:0] thresh;
  logic       hold;
  logic [7:0] light;
  logic       alarm;
  int tests = 0;
  int fails = 0;

  led_status_drv #(.CH(2), .W(4), .DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .values(values),
    .mode  (mode),
    .thresh(thresh),
    .hold  (hold),
    .light (light),
    .alarm (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; values = 8'h31; thresh = 4'hF; hold = 1'b0;
    #2;
    chk("reset_light", light, 8'h00);
    chk("reset_alarm", {7'd0, alarm}, 8'h00);
    clks(1);
    rst_n = 1'b1;
    clks(2);
    chk("direct_rev", light, 8'b1100_1000);
    chk("direct_noalarm", {7'd0, alarm}, 8'h00);

    values = 8'hFF;
    clks(2);
    chk("direct_ff", light, 8'hFF);
    mode = 2'b01;
    for (int k = 0; k < 16; k++) begin
      clks(1);
      chk($sformatf("blink_%0d", k), light, ((k / 4) % 2 == 0) ? 8'hFF : 8'h00);
    end

    mode = 2'b00; values = 8'h95; thresh = 4'h5;
    clks(2);
    chk("alarm_pre_light", light, 8'h9A);
    chk("alarm_pre_alarm", {7'd0, alarm}, 8'h01);
    mode = 2'b10;
    for (int k = 0; k < 8; k++) begin
      clks(1);
      chk($sformatf("alarmblink_%0d", k), light, (k < 4) ? 8'h9A : 8'h0A);
    end
    chk("alarmblink_alarm", {7'd0, alarm}, 8'h01);
    values = 8'h55;
    clks(2);
    chk("equal_noalarm", {7'd0, alarm}, 8'h00);
    chk("equal_steady", light, 8'hAA);

    hold = 1'b1; thresh = 4'h4;
    clks(1);
    chk("thresh_under_hold", {7'd0, alarm}, 8'h01);
    hold = 1'b0;

    mode = 2'b11; values = 8'hFF;
    clks(2);
    chk("off_light", light, 8'h00);
    chk("off_alarm", {7'd0, alarm}, 8'h01);

    mode = 2'b00; values = 8'h21; thresh = 4'hF;
    clks(2);
    chk("hold_pre", light, 8'h48);
    hold = 1'b1; values = 8'h00;
    clks(3);
    chk("hold_frozen", light, 8'h48);
    chk("hold_noalarm", {7'd0, alarm}, 8'h00);
    hold = 1'b0;
    clks(1);
    chk("release_1", light, 8'h48);
    clks(1);
    chk("release_2", light, 8'h00);

    thresh = 4'h0; values = 8'hFF; mode = 2'b01;
    clks(5);
    chk("midblink_dark", light, 8'h00);
    chk("midblink_alarm", {7'd0, alarm}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_light", light, 8'h00);
    chk("async_alarm", {7'd0, alarm}, 8'h00);
    clks(1);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      clks(1);
      chk($sformatf("restart_%0d", k), light, (k >= 1 && k <= 3) || k == 8 ? 8'hFF : 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
